// File: rtl/ghostbus_arb_pkg.sv
// ghostbus_arb_pkg -- shared types and helpers for the two-host ghostbus arbiter.
//
// Contents:
//   arb_state_e   arbiter FSM state (IDLE / WRITE / READ_WAIT / READ_DONE)
//   HOST0/HOST1   host index constants, also the encoding of grant/last_grant
//   lat_cnt_w()   width of the read-latency down-counter, clog2(RD+1)
//
// Optional feature macro (consumed by ghostbus_arb_pick):
//   GHOSTBUS_ARB_RR_EN  round-robin tie-break instead of fixed host-0 priority

package ghostbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        READ_DONE = 2'd3
    } arb_state_e;

    localparam logic HOST0 = 1'b0;
    localparam logic HOST1 = 1'b1;

    // The counter is loaded with RD itself, so it must be able to hold RD.
    function automatic int unsigned lat_cnt_w(input int unsigned rd);
        return $clog2(rd + 1);
    endfunction

endpackage

// File: rtl/ghostbus_arb_pick.sv
// ghostbus_arb_pick -- combinational winner select for the ghostbus arbiter.
//
// Keeps the arbitration policy out of the FSM: the FSM only asks "is anyone
// requesting" and "who wins", whatever the policy.
//
// Ports:
//   h0_valid_i    host 0 request pending
//   h1_valid_i    host 1 request pending
//   last_grant_i  host granted most recently (HOST0/HOST1)
//   any_o         at least one host requesting
//   winner_o      host to grant this cycle (meaningful only when any_o)
//
// Macro GHOSTBUS_ARB_RR_EN:
//   defined   -> round-robin: a tie goes to the host that did not win last
//   undefined -> fixed priority: host 0 wins every tie (host 1 can starve)

module ghostbus_arb_pick
    import ghostbus_arb_pkg::*;
(
    input  logic h0_valid_i,
    input  logic h1_valid_i,
    input  logic last_grant_i,
    output logic any_o,
    output logic winner_o
);

    assign any_o = h0_valid_i | h1_valid_i;

`ifdef GHOSTBUS_ARB_RR_EN
    always_comb begin
        winner_o = HOST0;
        if (h0_valid_i && h1_valid_i) begin
            winner_o = ~last_grant_i;
        end else if (h1_valid_i) begin
            winner_o = HOST1;
        end
    end
`else
    // Fixed priority has no use for the grant history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        winner_o = HOST0;
        if (!h0_valid_i && h1_valid_i) begin
            winner_o = HOST1;
        end
    end
`endif

endmodule

// File: rtl/ghostbus_arbiter.sv
// ghostbus_arbiter -- shares one ghostbus master port between two hosts.
//
// One transaction is outstanding at a time. A grant in IDLE latches the
// winner's address/data onto the bus; a write then pulses gb_wen together with
// the host ack, a read pulses gb_rstb, counts RD cycles, samples gb_rdata and
// acks one cycle later with the captured data.
//
// Parameters:
//   AW  bus address width
//   DW  bus data width
//   RD  read latency, gb_rstb to valid gb_rdata, in cycles (1..255)
//
// Ports:
//   gb_clk, gb_rst_n          clock (rising edge), async active-low reset
//   hN_valid/we/addr/wdata    host N request, held until hN_ack (N = 0,1)
//   hN_ack                    host N one-cycle completion pulse
//   hN_rdata                  host N read data, valid with hN_ack on reads
//   gb_addr, gb_wdata         bus address / write data, held grant to grant
//   gb_wen, gb_rstb           one-cycle bus write / read strobes
//   gb_rdata                  bus read data
//
// Macro GHOSTBUS_ARB_RR_EN selects round-robin over fixed priority
// (see ghostbus_arb_pick).

module ghostbus_arbiter
    import ghostbus_arb_pkg::*;
#(
    parameter int unsigned AW = 24,
    parameter int unsigned DW = 32,
    parameter int unsigned RD = 8
) (
    input  logic          gb_clk,
    input  logic          gb_rst_n,

    input  logic          h0_valid,
    input  logic          h0_we,
    input  logic [AW-1:0] h0_addr,
    input  logic [DW-1:0] h0_wdata,
    output logic          h0_ack,
    output logic [DW-1:0] h0_rdata,

    input  logic          h1_valid,
    input  logic          h1_we,
    input  logic [AW-1:0] h1_addr,
    input  logic [DW-1:0] h1_wdata,
    output logic          h1_ack,
    output logic [DW-1:0] h1_rdata,

    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata
);

    localparam int unsigned CW = lat_cnt_w(RD);

    arb_state_e    state_q;
    logic          gnt_q;          // host owning the current transaction
    logic          last_grant_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          wen_q;
    logic          rstb_q;
    logic [1:0]    ack_q;          // indexed by host
    logic [DW-1:0] h0_rdata_q;
    logic [DW-1:0] h1_rdata_q;

    logic          any_req;
    logic          winner;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    ghostbus_arb_pick u_pick (
        .h0_valid_i   (h0_valid),
        .h1_valid_i   (h1_valid),
        .last_grant_i (last_grant_q),
        .any_o        (any_req),
        .winner_o     (winner)
    );

    // Request fields of the winning host; only sampled on a grant, so later
    // changes on the host side never reach the bus.
    always_comb begin
        win_we    = h0_we;
        win_addr  = h0_addr;
        win_wdata = h0_wdata;
        if (winner == HOST1) begin
            win_we    = h1_we;
            win_addr  = h1_addr;
            win_wdata = h1_wdata;
        end
    end

    // Strobes and acks are registered pulses: every state that raises one
    // leaves after a single cycle, so clearing them by default each cycle is
    // what keeps them one cycle wide. Reset clears them asynchronously, which
    // also drops an in-flight transaction without an ack.
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= HOST0;
            last_grant_q <= HOST1;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            rstb_q       <= 1'b0;
            ack_q        <= '0;
            h0_rdata_q   <= '0;
            h1_rdata_q   <= '0;
        end else begin
            wen_q  <= 1'b0;
            rstb_q <= 1'b0;
            ack_q  <= '0;

            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q        <= winner;
                        last_grant_q <= winner;
                        addr_q       <= win_addr;
                        wdata_q      <= win_wdata;
                        if (win_we) begin
                            // Write completes on the strobe cycle itself.
                            state_q       <= WRITE;
                            wen_q         <= 1'b1;
                            ack_q[winner] <= 1'b1;
                        end else begin
                            state_q <= READ_WAIT;
                            rstb_q  <= 1'b1;
                            cnt_q   <= CW'(RD);
                        end
                    end
                end

                WRITE: begin
                    state_q <= IDLE;
                end

                READ_WAIT: begin
                    // Counter reads RD in the strobe cycle and 0 exactly RD
                    // cycles later, which is when gb_rdata is valid.
                    if (cnt_q == '0) begin
                        state_q      <= READ_DONE;
                        ack_q[gnt_q] <= 1'b1;
                        if (gnt_q == HOST0) begin
                            h0_rdata_q <= gb_rdata;
                        end else begin
                            h1_rdata_q <= gb_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                READ_DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gb_addr  = addr_q;
    assign gb_wdata = wdata_q;
    assign gb_wen   = wen_q;
    assign gb_rstb  = rstb_q;
    assign h0_ack   = ack_q[0];
    assign h1_ack   = ack_q[1];
    assign h0_rdata = h0_rdata_q;
    assign h1_rdata = h1_rdata_q;

endmodule

// File: tb/tb_ghostbus_arbiter.sv
// tb_ghostbus_arbiter -- self-checking bench for ghostbus_arbiter.
//
// Two instances (RD=8 and RD=1) share the host and bus inputs; sel1 picks
// whose outputs are checked. The reference is a transaction scheduler: when
// the arbiter is free and someone is requesting, it picks a winner by policy
// and books the expected strobe/ack cycles and data from the timing rules.
// gb_rdata changes every cycle, so the expected read data pins down the exact
// sampling cycle.

module tb_ghostbus_arbiter;

    localparam int AW   = 24;
    localparam int DW   = 32;
    localparam int MAXC = 4096;
`ifdef GHOSTBUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          gb_clk   = 1'b0;
    logic          gb_rst_n = 1'b0;
    logic          h0_valid, h0_we, h1_valid, h1_we;
    logic [AW-1:0] h0_addr, h1_addr;
    logic [DW-1:0] h0_wdata, h1_wdata, gb_rdata;

    logic          a_h0_ack, a_h1_ack, a_wen, a_rstb;
    logic [DW-1:0] a_h0_rdata, a_h1_rdata, a_wdata;
    logic [AW-1:0] a_addr;
    logic          b_h0_ack, b_h1_ack, b_wen, b_rstb;
    logic [DW-1:0] b_h0_rdata, b_h1_rdata, b_wdata;
    logic [AW-1:0] b_addr;

    always #5 gb_clk = ~gb_clk;

    ghostbus_arbiter #(.AW(AW), .DW(DW), .RD(8)) dut8 (
        .gb_clk(gb_clk), .gb_rst_n(gb_rst_n),
        .h0_valid(h0_valid), .h0_we(h0_we), .h0_addr(h0_addr), .h0_wdata(h0_wdata),
        .h0_ack(a_h0_ack), .h0_rdata(a_h0_rdata),
        .h1_valid(h1_valid), .h1_we(h1_we), .h1_addr(h1_addr), .h1_wdata(h1_wdata),
        .h1_ack(a_h1_ack), .h1_rdata(a_h1_rdata),
        .gb_addr(a_addr), .gb_wdata(a_wdata), .gb_wen(a_wen), .gb_rstb(a_rstb),
        .gb_rdata(gb_rdata)
    );

    ghostbus_arbiter #(.AW(AW), .DW(DW), .RD(1)) dut1 (
        .gb_clk(gb_clk), .gb_rst_n(gb_rst_n),
        .h0_valid(h0_valid), .h0_we(h0_we), .h0_addr(h0_addr), .h0_wdata(h0_wdata),
        .h0_ack(b_h0_ack), .h0_rdata(b_h0_rdata),
        .h1_valid(h1_valid), .h1_we(h1_we), .h1_addr(h1_addr), .h1_wdata(h1_wdata),
        .h1_ack(b_h1_ack), .h1_rdata(b_h1_rdata),
        .gb_addr(b_addr), .gb_wdata(b_wdata), .gb_wen(b_wen), .gb_rstb(b_rstb),
        .gb_rdata(gb_rdata)
    );

    bit            sel1 = 1'b0;
    logic          o_wen, o_rstb, o_ack0, o_ack1;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_rd0, o_rd1;
    assign o_wen   = sel1 ? b_wen      : a_wen;
    assign o_rstb  = sel1 ? b_rstb     : a_rstb;
    assign o_ack0  = sel1 ? b_h0_ack   : a_h0_ack;
    assign o_ack1  = sel1 ? b_h1_ack   : a_h1_ack;
    assign o_addr  = sel1 ? b_addr     : a_addr;
    assign o_wdata = sel1 ? b_wdata    : a_wdata;
    assign o_rd0   = sel1 ? b_h0_rdata : a_h0_rdata;
    assign o_rd1   = sel1 ? b_h1_rdata : a_h1_rdata;

    typedef struct {
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            gap;
    } txn_t;

    int n_chk = 0;
    int n_err = 0;

    // reference state
    txn_t          hq[2][$];
    txn_t          cur[2];
    bit            hv[2], hg[2];
    int            hack[2];
    int            cyc, free_at, last, m_rd, pend, fix_cyc;
    logic [DW-1:0] fix_val;
    logic [AW-1:0] m_addr, pa;
    logic [DW-1:0] m_wdata, pw;
    logic [DW-1:0] m_rdata[2], rdv_val[2];
    int            rdv_cyc[2];
    bit            e_wen[MAXC], e_rstb[MAXC], e_ack0[MAXC], e_ack1[MAXC];

    // observations of the selected DUT
    int            n_wen, n_rstb, viol;
    int            n_ack[2], first_ack[2];
    logic [DW-1:0] ack_rd[2];
    bit            prev_stb;
    int            ack_seq[$], wen_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int c);
        if (c == fix_cyc) return fix_val;
        return (DW'(c) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic int pick(input bit v0, input bit v1, input int lst);
        if (v0 && v1) return RR ? ((lst == 0) ? 1 : 0) : 0;
        return v0 ? 0 : 1;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic drive_idle();
        h0_valid = 1'b0; h0_we = 1'b0; h0_addr = '0; h0_wdata = '0;
        h1_valid = 1'b0; h1_we = 1'b0; h1_addr = '0; h1_wdata = '0;
    endtask

    task automatic push(input int h, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gap);
        txn_t t;
        t.we = we; t.a = a; t.d = d; t.gap = gap;
        hq[h].push_back(t);
    endtask

    task automatic push_rand(input int h, input int n);
        for (int i = 0; i < n; i++)
            push(h, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom_range(0, 3));
    endtask

    task automatic model_init();
        cyc = 0; free_at = 0; last = 1; pend = -1; fix_cyc = -1; fix_val = '0;
        m_addr = '0; m_wdata = '0; pa = '0; pw = '0;
        for (int h = 0; h < 2; h++) begin
            hq[h].delete();
            hv[h] = 1'b0; hg[h] = 1'b0; hack[h] = -1;
            m_rdata[h] = '0; rdv_val[h] = '0; rdv_cyc[h] = -1;
            n_ack[h] = 0; first_ack[h] = -1; ack_rd[h] = '0;
        end
        for (int i = 0; i < MAXC; i++) begin
            e_wen[i] = 1'b0; e_rstb[i] = 1'b0; e_ack0[i] = 1'b0; e_ack1[i] = 1'b0;
        end
        n_wen = 0; n_rstb = 0; viol = 0; prev_stb = 1'b0;
        ack_seq.delete(); wen_cyc.delete();
        drive_idle();
    endtask

    task automatic do_reset();
        drive_idle();
        gb_rst_n = 1'b0;
        repeat (2) @(posedge gb_clk);
        @(negedge gb_clk);
        chk("rst_wen",   64'(o_wen),   64'(0));
        chk("rst_rstb",  64'(o_rstb),  64'(0));
        chk("rst_ack0",  64'(o_ack0),  64'(0));
        chk("rst_ack1",  64'(o_ack1),  64'(0));
        chk("rst_addr",  64'(o_addr),  64'(0));
        chk("rst_wdata", 64'(o_wdata), 64'(0));
        chk("rst_rd0",   64'(o_rd0),   64'(0));
        chk("rst_rd1",   64'(o_rd1),   64'(0));
        @(posedge gb_clk); #1;
        gb_rst_n = 1'b1;
        model_init();
    endtask

    task automatic run(input int n);
        txn_t t;
        int   w;
        for (int k = 0; k < n; k++) begin
            @(posedge gb_clk); #1;
            cyc++;
            gb_rdata = pat(cyc);
            if (cyc == pend) begin m_addr = pa; m_wdata = pw; end
            for (int h = 0; h < 2; h++)
                if (cyc == rdv_cyc[h]) m_rdata[h] = rdv_val[h];

            // hosts: retire after the ack cycle, then present the next request
            for (int h = 0; h < 2; h++) begin
                if (hv[h] && hg[h] && cyc > hack[h]) begin hv[h] = 1'b0; hg[h] = 1'b0; end
                if (!hv[h] && hq[h].size() > 0) begin
                    t = hq[h].pop_front();
                    if (t.gap > 0) begin t.gap--; hq[h].push_front(t); end
                    else begin cur[h] = t; hv[h] = 1'b1; end
                end
            end

            // after a grant the request fields are scrambled: must be ignored
            h0_valid = hv[0];
            h1_valid = hv[1];
            if (hg[0]) begin h0_we = 1'($urandom); h0_addr = AW'($urandom); h0_wdata = $urandom; end
            else       begin h0_we = cur[0].we; h0_addr = cur[0].a; h0_wdata = cur[0].d; end
            if (hg[1]) begin h1_we = 1'($urandom); h1_addr = AW'($urandom); h1_wdata = $urandom; end
            else       begin h1_we = cur[1].we; h1_addr = cur[1].a; h1_wdata = cur[1].d; end

            // schedule the transaction granted this cycle
            if (cyc >= free_at && (hv[0] || hv[1])) begin
                w = pick(hv[0], hv[1], last);
                last = w; hg[w] = 1'b1;
                pa = cur[w].a; pw = cur[w].d; pend = cyc + 1;
                if (cur[w].we) begin
                    e_wen[cyc+1] = 1'b1;
                    hack[w] = cyc + 1;
                    free_at = cyc + 2;
                end else begin
                    e_rstb[cyc+1] = 1'b1;
                    hack[w] = cyc + 2 + m_rd;
                    rdv_cyc[w] = cyc + 2 + m_rd;
                    rdv_val[w] = pat(cyc + 1 + m_rd);
                    free_at = cyc + 3 + m_rd;
                end
                if (w == 0) e_ack0[hack[w]] = 1'b1; else e_ack1[hack[w]] = 1'b1;
            end

            @(negedge gb_clk);
            chk("wen",   64'(o_wen),   64'(e_wen[cyc]));
            chk("rstb",  64'(o_rstb),  64'(e_rstb[cyc]));
            chk("ack0",  64'(o_ack0),  64'(e_ack0[cyc]));
            chk("ack1",  64'(o_ack1),  64'(e_ack1[cyc]));
            chk("addr",  64'(o_addr),  64'(m_addr));
            chk("wdata", 64'(o_wdata), 64'(m_wdata));
            chk("rd0",   64'(o_rd0),   64'(m_rdata[0]));
            chk("rd1",   64'(o_rd1),   64'(m_rdata[1]));

            if (o_wen === 1'b1) begin n_wen++; wen_cyc.push_back(cyc); end
            if (o_rstb === 1'b1) n_rstb++;
            if (o_wen === 1'b1 && o_rstb === 1'b1) viol++;
            if ((o_wen === 1'b1 || o_rstb === 1'b1) && prev_stb) viol++;
            prev_stb = (o_wen === 1'b1) || (o_rstb === 1'b1);
            if (o_ack0 === 1'b1) begin
                n_ack[0]++; ack_seq.push_back(0); ack_rd[0] = o_rd0;
                if (first_ack[0] < 0) first_ack[0] = cyc;
            end
            if (o_ack1 === 1'b1) begin
                n_ack[1]++; ack_seq.push_back(1); ack_rd[1] = o_rd1;
                if (first_ack[1] < 0) first_ack[1] = cyc;
            end
        end
    endtask

    initial begin
        m_rd = 8;
        sel1 = 1'b0;

        // host 0 single write
        do_reset();
        push(0, 1'b1, 24'h000010, 32'hDEADBEEF, 0);
        run(6);
        chk("a_nwen",    64'(n_wen),        64'(1));
        chk("a_wencyc",  64'(qget(wen_cyc, 0)), 64'(2));
        chk("a_ackcyc",  64'(first_ack[0]), 64'(2));
        chk("a_noack1",  64'(n_ack[1]),     64'(0));

        // host 1 read, bus returns 0x12345678 RD cycles after the strobe
        do_reset();
        fix_cyc = 10; fix_val = 32'h12345678;
        push(1, 1'b0, 24'h000020, 32'h0, 0);
        run(15);
        chk("b_ackcyc",  64'(first_ack[1]), 64'(11));
        chk("b_rdata",   64'(ack_rd[1]),    64'(32'h12345678));
        chk("b_nrstb",   64'(n_rstb),       64'(1));
        chk("b_noack0",  64'(n_ack[0]),     64'(0));

        // both hosts streaming writes
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push(0, 1'b1, AW'(24'h100 + i), 32'hA000_0000 + i, 0);
            push(1, 1'b1, AW'(24'h200 + i), 32'hB000_0000 + i, 0);
        end
        run(30);
        for (int i = 0; i < 4; i++)
            chk("c_seq", 64'(qget(ack_seq, i)), 64'(RR ? (i % 2) : 0));
        for (int i = 0; i < 3; i++)
            chk("c_wencyc", 64'(qget(wen_cyc, i)), 64'(2 + 2 * i));
        chk("c_nwen", 64'(n_wen), 64'(12));

        // host 1 write arrives while host 0 read is in flight
        do_reset();
        push(0, 1'b0, 24'h000030, 32'h0, 0);
        push(1, 1'b1, 24'h000034, 32'hCAFE0001, 2);
        run(20);
        chk("d_ack0cyc", 64'(first_ack[0]), 64'(11));
        chk("d_wencyc",  64'(qget(wen_cyc, 0)), 64'(13));
        chk("d_ack1cyc", 64'(first_ack[1]), 64'(13));
        chk("d_viol",    64'(viol),         64'(0));

        // reset during an active write strobe drops it at once
        do_reset();
        push(0, 1'b1, 24'h000050, 32'h55AA55AA, 0);
        run(1);
        @(posedge gb_clk); #1;
        chk("e2_wen_pre", 64'(o_wen), 64'(1));
        gb_rst_n = 1'b0;
        #1;
        chk("e2_wen",  64'(o_wen),  64'(0));
        chk("e2_ack0", 64'(o_ack0), 64'(0));
        chk("e2_addr", 64'(o_addr), 64'(0));

        // reset three cycles into a read: no ack afterwards, fresh read works
        do_reset();
        push(0, 1'b0, 24'h000040, 32'h0, 0);
        run(4);
        gb_rst_n = 1'b0;
        #1;
        chk("e_rstb", 64'(o_rstb), 64'(0));
        chk("e_ack0", 64'(o_ack0), 64'(0));
        chk("e_addr", 64'(o_addr), 64'(0));
        model_init();
        @(posedge gb_clk); #1;
        gb_rst_n = 1'b1;
        run(15);
        chk("e_noack", 64'(n_ack[0]), 64'(0));
        push(0, 1'b0, 24'h000044, 32'h0, 0);
        run(14);
        chk("e_ackcyc", 64'(first_ack[0]), 64'(26));
        chk("e_rdata",  64'(ack_rd[0]),    64'(pat(25)));

        // random traffic, RD=8
        do_reset();
        push_rand(0, 80);
        push_rand(1, 80);
        run(2400);
        chk("r8_nack0", 64'(n_ack[0]), 64'(80));
        chk("r8_nack1", 64'(n_ack[1]), 64'(80));
        chk("r8_viol",  64'(viol),     64'(0));

        // RD=1 instance
        sel1 = 1'b1;
        m_rd = 1;
        do_reset();
        push(0, 1'b0, 24'h000060, 32'h0, 0);
        run(6);
        chk("f_rstbcyc", 64'(n_rstb),       64'(1));
        chk("f_ackcyc",  64'(first_ack[0]), 64'(4));
        chk("f_rdata",   64'(ack_rd[0]),    64'(pat(3)));

        do_reset();
        push_rand(0, 80);
        push_rand(1, 80);
        run(1200);
        chk("r1_nack0", 64'(n_ack[0]), 64'(80));
        chk("r1_nack1", 64'(n_ack[1]), 64'(80));
        chk("r1_viol",  64'(viol),     64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
